// File: rtl/csa_row_accumulator.sv
// Sequential carry-save accumulator: folds aligned partial-product rows into a
// registered (sum, carry) pair with 3:2 full-adder rows, LANES rows per beat.
module csa_row_accumulator #(
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned TERMS      = 24,
   parameter int unsigned LANES      = 1,
   parameter int unsigned SHIFT_STEP = 1,
   parameter int unsigned ACC_W      = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_term,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_sum,
   output logic [ACC_W-1:0]         out_carry,
   output logic                     busy
);

   localparam int unsigned SAFE_LANES = (LANES == 0) ? 1 : LANES;
   localparam int unsigned BEATS      = TERMS / SAFE_LANES;
   localparam int unsigned CNT_W      = (BEATS < 2) ? 1 : $clog2(BEATS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   generate
      if ((LANES != 1 && LANES != 2) || (TERMS % SAFE_LANES) != 0) begin : g_param_check
         $error("csa_row_accumulator: LANES must be 1 or 2 and divide TERMS");
      end
   endgenerate

   logic [1:0]       state;
   logic [CNT_W-1:0] beat;
   logic [ACC_W-1:0] acc_s;
   logic [ACC_W-1:0] acc_c;

   logic [ACC_W-1:0] fold_s;
   logic [ACC_W-1:0] fold_c;
   logic [ACC_W-1:0] row_t;
   logic [ACC_W-1:0] next_s;
   logic [WIDTH-1:0] lane_row;
   int unsigned      beat_idx;
   int unsigned      beat_nxt;
   logic             last_beat;
   logic             accept;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state != S_DONE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign out_sum   = acc_s;
   assign out_carry = acc_c;

   // An IDLE beat starts from a zero accumulator at row index 0, so stale
   // contents left from the previous result never leak into a new operation.
   always_comb begin
      fold_s   = (state == S_IDLE) ? '0 : acc_s;
      fold_c   = (state == S_IDLE) ? '0 : acc_c;
      beat_idx = (state == S_IDLE) ? 0 : 32'(beat);
      beat_nxt = beat_idx + 1;
      last_beat = (beat_nxt == BEATS);
      row_t    = '0;
      next_s   = '0;
      lane_row = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_row = in_term[l*WIDTH +: WIDTH];
         row_t    = ACC_W'(lane_row) << ((beat_idx * LANES + l) * SHIFT_STEP);
         next_s   = fold_s ^ fold_c ^ row_t;
         fold_c   = ((fold_s & fold_c) | (fold_s & row_t) | (fold_c & row_t)) << 1;
         fold_s   = next_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         beat  <= '0;
         acc_s <= '0;
         acc_c <= '0;
      end else begin
         case (state)
            S_IDLE, S_ACCUM: begin
               if (accept) begin
                  acc_s <= fold_s;
                  acc_c <= fold_c;
                  beat  <= CNT_W'(beat_nxt);
                  state <= last_beat ? S_DONE : S_ACCUM;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
                  beat  <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               beat  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_row_accumulator.sv
// Directed bench for csa_row_accumulator: default 24x24 multiply, a two-lane
// instance, and a narrow pre-aligned instance, with hand-computed results.
module tb_csa_row_accumulator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // default instance
   logic        v0, rdy0, ov0, or0, busy0;
   logic [23:0] t0;
   logic [47:0] s0, c0;
   // two-lane instance
   logic        v1, rdy1, ov1, or1, busy1;
   logic [47:0] t1;
   logic [47:0] s1, c1;
   // narrow, pre-aligned instance
   logic        v2, rdy2, ov2, or2, busy2;
   logic [7:0]  t2;
   logic [7:0]  s2, c2;

   csa_row_accumulator #(.WIDTH(24), .TERMS(24), .LANES(1), .SHIFT_STEP(1), .ACC_W(48)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_term(t0),
      .out_valid(ov0), .out_ready(or0), .out_sum(s0), .out_carry(c0), .busy(busy0));

   csa_row_accumulator #(.WIDTH(24), .TERMS(24), .LANES(2), .SHIFT_STEP(1), .ACC_W(48)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_term(t1),
      .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_carry(c1), .busy(busy1));

   csa_row_accumulator #(.WIDTH(8), .TERMS(3), .LANES(1), .SHIFT_STEP(0), .ACC_W(8)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_term(t2),
      .out_valid(ov2), .out_ready(or2), .out_sum(s2), .out_carry(c2), .busy(busy2));

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      bit          gaps;
      int          stall;
      logic [47:0] prod;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Rows k = a & {24{b[k]}}, one per beat; called and returns on a negedge.
   task automatic op0(input logic [23:0] a, input logic [23:0] b, input bit gaps,
                      input int stall, input logic [47:0] prod);
      int k, cyc, guard;
      bit started, tog, acc;
      logic [47:0] hs, hc;
      k = 0; cyc = 0; guard = 0; started = 0; tog = 1'b1;
      while (!ov0 && guard < 200) begin
         if (k < 24) begin
            v0 = gaps ? tog : 1'b1;
            tog = ~tog;
            t0 = b[k] ? a : 24'h0;
         end else begin
            v0 = 1'b0;
            t0 = 24'h0;
         end
         acc = v0 && rdy0;
         @(negedge clk);
         if (acc) begin k++; started = 1'b1; end
         if (started) cyc++;
         guard++;
      end
      v0 = 1'b0;
      t0 = 24'h0;
      chk("op0_done", ov0, 1);
      if (!gaps) chk("op0_latency", cyc + 1, 25);
      chk("op0_sum", 48'(s0 + c0), prod);
      chk("op0_carry_lsb", c0[0], 0);
      chk("op0_ready_in_done", rdy0, 0);
      chk("op0_busy_in_done", busy0, 1);
      hs = s0; hc = c0;
      for (int i = 0; i < stall; i++) begin
         or0 = 1'b0;
         @(negedge clk);
         chk("op0_stall_valid", ov0, 1);
         chk("op0_stall_ready", rdy0, 0);
         chk("op0_stall_stable", {s0, c0}, {hs, hc});
      end
      // offered beat during the release cycle must not be taken
      v0 = 1'b1; t0 = 24'hABCDEF; or0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0; t0 = 24'h0; or0 = 1'b0;
      chk("op0_release_valid", ov0, 0);
      chk("op0_release_busy", busy0, 0);
      chk("op0_release_ready", rdy0, 1);
   endtask

   task automatic op1(input logic [23:0] a, input logic [23:0] b, input logic [47:0] prod);
      int j, cyc, guard;
      bit started;
      j = 0; cyc = 0; guard = 0; started = 0;
      while (!ov1 && guard < 100) begin
         if (j < 12) begin
            v1 = 1'b1;
            t1 = {(b[2*j+1] ? a : 24'h0), (b[2*j] ? a : 24'h0)};
         end else begin
            v1 = 1'b0;
            t1 = 48'h0;
         end
         @(negedge clk);
         if (v1) begin j++; started = 1'b1; end
         if (started) cyc++;
         guard++;
      end
      v1 = 1'b0;
      t1 = 48'h0;
      chk("op1_done", ov1, 1);
      chk("op1_latency", cyc + 1, 13);
      chk("op1_sum", 48'(s1 + c1), prod);
      chk("op1_carry_lsb", c1[0], 0);
      v1 = 1'b1; t1 = 48'h123456789ABC; or1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0; t1 = 48'h0; or1 = 1'b0;
      chk("op1_release_valid", ov1, 0);
      chk("op1_release_ready", rdy1, 1);
   endtask

   task automatic op2(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                      input logic [7:0] res);
      logic [7:0] rows [3];
      int cyc;
      rows[0] = r0; rows[1] = r1; rows[2] = r2;
      cyc = 0;
      for (int i = 0; i < 3; i++) begin
         v2 = 1'b1;
         t2 = rows[i];
         @(negedge clk);
         cyc++;
      end
      v2 = 1'b0;
      t2 = 8'h0;
      chk("op2_done", ov2, 1);
      chk("op2_latency", cyc + 1, 4);
      chk("op2_sum", 8'(s2 + c2), res);
      chk("op2_carry_lsb", c2[0], 0);
      or2 = 1'b1;
      @(negedge clk);
      or2 = 1'b0;
      chk("op2_release_valid", ov2, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 0, 48'hFFFFFE000001};
      vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 5, 48'hFFFFFE000001};
      vecs[2] = '{24'h800000, 24'h000003, 1'b0, 0, 48'h000001800000};
      vecs[3] = '{24'h123456, 24'h000010, 1'b0, 2, 48'h000001234560};
      vecs[4] = '{24'h000000, 24'hFFFFFF, 1'b0, 0, 48'h000000000000};
      vecs[5] = '{24'hFFFFFF, 24'h000001, 1'b1, 0, 48'h000000FFFFFF};
      vecs[6] = '{24'h000002, 24'h800000, 1'b0, 1, 48'h000001000000};
      vecs[7] = '{24'hABCDEF, 24'h000101, 1'b0, 0, 48'h0000AC79BCEF};

      // reset held with valid asserted
      rst = 1'b1;
      v0 = 1'b1; t0 = 24'hFFFFFF; or0 = 1'b0;
      v1 = 1'b1; t1 = '1;         or1 = 1'b0;
      v2 = 1'b1; t2 = 8'hFF;      or2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", rdy0, 1);
      chk("rst_out_valid", ov0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_sum", s0, 0);
      chk("rst_carry", c0, 0);
      chk("rst_lanes2_ready", rdy1, 1);
      chk("rst_narrow_busy", busy2, 0);
      rst = 1'b0;
      v0 = 1'b0; t0 = '0;
      v1 = 1'b0; t1 = '0;
      v2 = 1'b0; t2 = '0;
      @(negedge clk);
      chk("post_rst_busy", busy0, 0);

      for (int i = 0; i < 8; i++)
         op0(vecs[i].a, vecs[i].b, vecs[i].gaps, vecs[i].stall, vecs[i].prod);

      // reset in the middle of an operation
      for (int i = 0; i < 10; i++) begin
         v0 = 1'b1; t0 = 24'hFFFFFF;
         @(negedge clk);
      end
      chk("midop_busy", busy0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; v0 = 1'b0; t0 = '0;
      chk("midop_rst_ready", rdy0, 1);
      chk("midop_rst_busy", busy0, 0);
      chk("midop_rst_valid", ov0, 0);
      chk("midop_rst_sum", s0, 0);
      chk("midop_rst_carry", c0, 0);
      op0(24'h800000, 24'h000003, 1'b0, 0, 48'h000001800000);

      // two lanes per beat
      op1(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      op1(24'h800000, 24'h000003, 48'h000001800000);
      op1(24'hABCDEF, 24'h000101, 48'h0000AC79BCEF);

      // pre-aligned 8-bit rows, result wraps mod 256
      op2(8'hFF, 8'hFF, 8'h02, 8'h00);
      op2(8'h01, 8'h02, 8'h03, 8'h06);
      op2(8'h80, 8'h80, 8'h80, 8'h80);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
